uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_transmitter between NUM_REQ byte-stream requesters (e.g. console, debug, CPU MMIO).
//  Grants one requester at a time, round-robin, and holds the grant for a whole message (until 'last').
//  A forced release after MAX_BURST bytes prevents starvation.
//  Sits between the requesters and the data_in/data_in_valid/data_in_ready port of uart_transmitter.
// PARAMETERS
//  NUM_REQ    4    number of requesters; legal range 2..16
//  MAX_BURST  64   maximum bytes per grant before forced release; legal range 1..255
// PORTS
//  clk            in   1          system clock; all logic on its rising edge
//  reset_n        in   1          asynchronous, active-low reset
//  req_data       in   8*NUM_REQ  byte from requester i, in bits [8*i+7:8*i]
//  req_valid      in   NUM_REQ    requester i has a byte
//  req_last       in   NUM_REQ    requester i's current byte ends its message
//  req_ready      out  NUM_REQ    byte from requester i accepted this cycle (valid&ready)
//  tx_data        out  8          to transmitter data_in
//  tx_valid       out  1          to transmitter data_in_valid
//  tx_ready       in   1          from transmitter data_in_ready
//  grant_valid    out  1          a requester currently owns the transmitter
//  grant_id       out  $clog2(NUM_REQ)  current/most recent owner index
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, owner=0, last_owner=NUM_REQ-1, burst_cnt=0.
//    Outputs while reset: req_ready=0, tx_valid=0, tx_data=0, grant_valid=0, grant_id=0.
//  States: IDLE, OWN.
//  IDLE:
//    - req_ready=0, tx_valid=0, tx_data=0.
//    - If any req_valid: pick the first valid index scanning last_owner+1, +2, ... (mod NUM_REQ).
//      Register it into owner, clear burst_cnt, go to OWN.
//    - Otherwise stay in IDLE.
//  OWN (combinational pass-through, no bubble inside a message):
//    - tx_data=req_data[owner], tx_valid=req_valid[owner].
//    - req_ready[owner]=tx_ready; req_ready of all other requesters = 0.
//    - Handshake = tx_valid & tx_ready: burst_cnt increments by 1.
//    - Handshake with req_last[owner]=1, or with burst_cnt==MAX_BURST-1:
//      last_owner<=owner, go to IDLE.
//    - Owner deasserting valid mid-message: grant is kept and bytes of other requesters stay blocked.
//      No timeout.
//  Latency: first byte of a message reaches tx_valid exactly 1 cycle after req_valid is seen in IDLE.
//    Minimum gap between messages is 1 IDLE cycle.
//  Simultaneous requests: round-robin order only. A requester that was just released has lowest priority next.
//  Forced release: the remaining bytes of that message are re-arbitrated. Requesters must tolerate interleaving after MAX_BURST.
//  grant_valid=(state==OWN); grant_id=owner (holds its value in IDLE).
//  burst_cnt width $clog2(MAX_BURST+1); it never wraps, because release occurs at MAX_BURST-1.
//  Reset asserted mid-message: immediate return to IDLE. The byte already taken by the transmitter is not tracked.
//  req_data/req_last of non-owners are don't-care.
//  Requester side is AXI-style: valid must not depend on ready.
// STRUCTURE
//  uart_pkg: UART_FRAME_BITS=10, arbiter state encoding (IDLE/OWN), byte width 8.
//  Sub-module rr_arbiter #(N): purely combinational.
//    Inputs: req[N], last_grant index. Outputs: any, grant index (rotating priority scan).
//  Top level: state/owner/burst_cnt flops, owner mux, req_ready demux.
// TESTING
//  1. Reset: reset_n=0 with random inputs -> tx_valid=0, req_ready=0, grant_valid=0.
//     After release, idle outputs remain 0.
//  2. Single message: req 2 sends 0x48,0x69(last), tx_ready always 1.
//     -> grant_id=2 one cycle after valid; tx_data 0x48 then 0x69; return to IDLE.
//  3. Contention: req 0,1,3 all valid with 1-byte messages.
//     -> grant order 0,1,3,0,... with last_owner=3 at start; no interleaving.
//  4. Backpressure: tx_ready low 1085 cycles per byte.
//     -> req_ready[owner] pulses only with tx_ready; data held stable; no drops or duplicates.
//  5. Burst limit: MAX_BURST=4, req 1 streams 6 bytes without last while req 2 is valid.
//     -> after 4 bytes grant moves to 2, then returns to 1 for bytes 5-6.
//  6. Reset mid-message: assert reset_n=0 while in OWN after byte 3 of 8.
//     -> outputs clear asynchronously; after release, arbitration restarts from req 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and the arbiter state encoding for the UART transmit path.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int BYTE_W          = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first request after last_grant wins.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic         any,
    output logic [W-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        any   = |req;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        // Offset 1..N so the previous owner is scanned last.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!found && req[idx]) begin
                grant = W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte streams,
// holding the grant for a full message or until MAX_BURST bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    arb_state_t      state;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  last_owner;
    logic [CW-1:0]   burst_cnt;
    logic            rr_any;
    logic [IDW-1:0]  rr_grant;
    logic [BYTE_W-1:0] bytes [NUM_REQ];
    logic            hs;

    rr_arbiter #(.N(NUM_REQ), .W(IDW)) u_rr (
        .req        (req_valid),
        .last_grant (last_owner),
        .any        (rr_any),
        .grant      (rr_grant)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bytes[i] = req_data[BYTE_W*i +: BYTE_W];
        end
    end

    // Pass-through while owned so a message streams without bubbles.
    always_comb begin
        req_ready = '0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        if (state == ST_OWN) begin
            tx_data          = bytes[owner];
            tx_valid         = req_valid[owner];
            req_ready[owner] = tx_ready;
        end
    end

    assign hs          = (state == ST_OWN) && tx_valid && tx_ready;
    assign grant_valid = (state == ST_OWN);
    assign grant_id    = owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= IDW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rr_any) begin
                        owner     <= rr_grant;
                        burst_cnt <= '0;
                        state     <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (hs) begin
                        burst_cnt <= burst_cnt + CW'(1);
                        if (req_last[owner] ||
                            burst_cnt == CW'(MAX_BURST - 1)) begin
                            last_owner <= owner;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
